// File: rtl/trace_pkg.sv
// Shared record layout for the CPU trace buffer: field widths, offsets and structs.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package trace_pkg;

    localparam int SEQ_W     = 8;
    localparam int INSTR_W   = 32;
    localparam int WB_W      = 16;
    localparam int PAYLOAD_W = INSTR_W + WB_W;
    localparam int REC_W     = SEQ_W + PAYLOAD_W;

    // Bit offsets of each field inside a packed record.
    localparam int WB_LSB    = 0;
    localparam int INSTR_LSB = 16;
    localparam int SEQ_LSB   = 48;

    // Captured core state, without the sequence tag.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [WB_W-1:0]    wb;
    } payload_t;

    // Full record as presented to the consumer, sequence number in the MSBs.
    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        payload_t         payload;
    } rec_t;

    function automatic payload_t make_payload(input logic [INSTR_W-1:0] instr,
                                              input logic [WB_W-1:0]    wb);
        payload_t p;
        p.instr = instr;
        p.wb    = wb;
        return p;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and wrapped pointers.
// Latency: a pushed entry is visible at the head the cycle after the push edge (no bypass).
// Backpressure: push is refused when full unless a pop happens in the same cycle; pop when empty is ignored.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 56
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign valid   = (level != '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign pop_ok  = pop & valid;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    // Storage array; contents are meaningless once level says the slot is free.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards every stored entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Captures {seq, instr, write-back} once per core clock fall into a FIFO drained over valid/ready.
// Latency: fall seen after 2 sync edges, pushed on the 3rd; rec_valid rises the cycle after the push.
// Backpressure: never stalls the core; records arriving while full are dropped and counted.
module cpu_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                     fast_clock,
    input  logic                     reset,
    input  logic                     clock,
    input  logic                     enable,
    input  logic [31:0]              instr,
    input  logic [15:0]              write_reg_data,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [SEQ_W+47:0]        rec_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);

    import trace_pkg::*;

    logic             s1;
    logic             s2;
    logic             s3;
    logic             fall_det;
    logic             push_req;
    logic             pop;
    logic             full;
    logic             drop;
    logic             push_ok;
    logic [SEQ_W-1:0] seq;
    payload_t         payload;

    // Bring the core clock into the fast domain; the third flop gives a clean edge reference.
    always_ff @(posedge fast_clock) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= clock;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Falling edge of the core clock: its outputs have settled by mid-cycle.
    assign fall_det = s3 & ~s2;
    assign push_req = fall_det & enable;
    assign pop      = rec_valid & rec_ready;
    assign drop     = push_req & full & ~pop;
    assign push_ok  = push_req & ~drop;

    // Sequence number advances for every captured instruction, kept or dropped, so gaps expose drops.
    always_ff @(posedge fast_clock) begin
        if (reset) begin
            seq <= '0;
        end else if (push_req) begin
            seq <= seq + SEQ_W'(1);
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge fast_clock) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    // Pack the core-side fields that ride behind the sequence number.
    always_comb begin
        payload = make_payload(instr, write_reg_data);
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SEQ_W + PAYLOAD_W)
    ) u_fifo (
        .clk       (fast_clock),
        .reset     (reset),
        .push      (push_ok),
        .push_data ({seq, payload}),
        .pop       (pop),
        .head      (rec_data),
        .valid     (rec_valid),
        .full      (full),
        .level     (level)
    );

endmodule

// File: tb/tb_cpu_trace_buffer.sv
module tb_cpu_trace_buffer;

    localparam int DEPTH = 16;
    localparam int SEQ_W = 8;
    localparam int CNT_W = 8;
    localparam int REC_W = SEQ_W + 48;

    logic                   fast_clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   clock = 1'b0;
    logic                   enable = 1'b0;
    logic [31:0]            instr = '0;
    logic [15:0]            write_reg_data = '0;
    logic                   rec_valid;
    logic                   rec_ready = 1'b0;
    logic [REC_W-1:0]       rec_data;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic [CNT_W-1:0]       drop_count;

    logic [REC_W-1:0] exp_q[$];
    logic [SEQ_W-1:0] tb_seq = '0;
    int               n_checks = 0;
    int               n_pass = 0;

    cpu_trace_buffer #(
        .DEPTH (DEPTH),
        .SEQ_W (SEQ_W),
        .CNT_W (CNT_W)
    ) dut (
        .fast_clock     (fast_clock),
        .reset          (reset),
        .clock          (clock),
        .enable         (enable),
        .instr          (instr),
        .write_reg_data (write_reg_data),
        .rec_valid      (rec_valid),
        .rec_ready      (rec_ready),
        .rec_data       (rec_data),
        .level          (level),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 fast_clock = ~fast_clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor: every presented head record must match the oldest expected one.
    always @(negedge fast_clock) begin
        if (!reset && rec_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_record: got 0x%0h expected no record at %0t", rec_data, $time);
            end else begin
                check("rec_data", 64'(rec_data), 64'(exp_q[0]));
                if (rec_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One core cycle: high phase, then a fall carrying the given fields; returns `settle` edges later.
    task automatic core_fall(input logic [31:0] i, input logic [15:0] w, input bit accept, input int settle);
        clock = 1'b1;
        repeat (5) @(posedge fast_clock);
        #1;
        instr = i;
        write_reg_data = w;
        clock = 1'b0;
        if (enable) begin
            if (accept) exp_q.push_back({tb_seq, i, w});
            tb_seq = tb_seq + 1'b1;
        end
        repeat (settle) @(posedge fast_clock);
        #1;
    endtask

    task automatic do_reset();
        rec_ready = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        tb_seq = '0;
        repeat (3) @(posedge fast_clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        rec_ready = 1'b1;
        for (int k = 0; k < 200 && level != 0; k++) begin
            @(posedge fast_clock);
            #1;
        end
        rec_ready = 1'b0;
        check({tag, "_drain_level"}, 64'(level), 64'd0);
        check({tag, "_drain_valid"}, 64'(rec_valid), 64'd0);
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge fast_clock);
        #1;
        reset = 1'b0;
        check("rst_valid", 64'(rec_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);

        // Single capture and its latency
        enable = 1'b1;
        core_fall(32'h2001_0005, 16'h0005, 1'b1, 2);
        check("t1_valid_early", 64'(rec_valid), 64'd0);
        repeat (2) @(posedge fast_clock);
        #1;
        check("t1_valid", 64'(rec_valid), 64'd1);
        check("t1_level", 64'(level), 64'd1);
        check("t1_head", 64'(rec_data), {8'h00, 56'h00_2001_0005_0005});
        repeat (4) @(posedge fast_clock);
        #1;
        drain("t1");

        // Three records stalled, then drained in order
        do_reset();
        core_fall(32'h0043_2820, 16'h1234, 1'b1, 6);
        core_fall(32'h8C22_0004, 16'hBEEF, 1'b1, 6);
        core_fall(32'hAC22_0008, 16'h0000, 1'b1, 6);
        check("t2_level", 64'(level), 64'd3);
        drain("t2");

        // Enable gating, captures while consumer is already ready (pop on empty ignored)
        do_reset();
        rec_ready = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) core_fall(32'hDEAD_0000 + 32'(i), 16'h00AA, 1'b1, 6);
        check("t5_level_disabled", 64'(level), 64'd0);
        enable = 1'b1;
        core_fall(32'h1234_5678, 16'h9ABC, 1'b1, 6);
        drain("t5");
        check("t5_drop", 64'(drop_count), 64'd0);

        // Overflow: 20 captures into 16 slots
        do_reset();
        for (int i = 0; i < 20; i++)
            core_fall(32'h1000_0000 + 32'(i), 16'(i * 3), (i < 16), 6);
        check("t3_level", 64'(level), 64'd16);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_drop", 64'(drop_count), 64'd4);

        // Full FIFO, capture coincident with a pop: accepted, seq=20
        core_fall(32'hCAFE_0020, 16'h0020, 1'b1, 2);
        rec_ready = 1'b1;
        @(posedge fast_clock);
        #1;
        rec_ready = 1'b0;
        check("t4_level", 64'(level), 64'd16);
        check("t4_drop", 64'(drop_count), 64'd4);
        check("t4_overflow", 64'(overflow), 64'd1);
        drain("t4");
        check("t4_overflow_sticky", 64'(overflow), 64'd1);

        // Reset with five records pending and drop state set
        for (int i = 0; i < 5; i++) core_fall(32'h5000_0000 + 32'(i), 16'(i), 1'b1, 6);
        check("t6_level_before", 64'(level), 64'd5);
        reset = 1'b1;
        exp_q.delete();
        tb_seq = '0;
        clock = 1'b1;
        @(posedge fast_clock);
        #1;
        check("t6_valid", 64'(rec_valid), 64'd0);
        check("t6_level", 64'(level), 64'd0);
        check("t6_overflow", 64'(overflow), 64'd0);
        check("t6_drop", 64'(drop_count), 64'd0);
        repeat (3) @(posedge fast_clock);
        #1;
        clock = 1'b0;
        @(posedge fast_clock);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge fast_clock);
        #1;
        check("t6_no_spurious_level", 64'(level), 64'd0);
        check("t6_no_spurious_valid", 64'(rec_valid), 64'd0);
        core_fall(32'h0BAD_F00D, 16'h7777, 1'b1, 6);
        check("t6_after_level", 64'(level), 64'd1);
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
